// File: rtl/ms_clk_pkg.sv
// Shared types and defaults for the MS clock/reset generator.
// Holds the source and switch-state enums, divider codes and the default timing constants.
// Also provides the ring-oscillator half-period helper used by the top.
package ms_clk_pkg;

    typedef enum logic [1:0] {
        SRC_OSC  = 2'd0,
        SRC_ROSC = 2'd1,
        SRC_X0   = 2'd2,
        SRC_X1   = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        SW_RUN      = 2'd0,
        SW_WAIT_LOW = 2'd1,
        SW_HOLD     = 2'd2
    } sw_state_e;

    localparam logic [1:0] DIV_1 = 2'd0;
    localparam logic [1:0] DIV_2 = 2'd1;
    localparam logic [1:0] DIV_4 = 2'd2;
    localparam logic [1:0] DIV_8 = 2'd3;

    localparam int HALF_W = 4;

    localparam int DEF_OSC_HALF   = 6;
    localparam int DEF_ROSC_HALF0 = 2;
    localparam int DEF_ROSC_STEP  = 1;
    localparam int DEF_POR_CYCLES = 16;
    localparam int DEF_STALL_LIM  = 256;

    function automatic logic [HALF_W-1:0] rosc_half(input int base, input int step,
                                                    input logic [1:0] code);
        return HALF_W'(base + step * int'(code));
    endfunction

endpackage

// File: rtl/ms_clk_tick_src.sv
// Half-period counter source: emits a tick every half_i ref cycles and toggles a level register.
// Latency: level_o changes on the clock edge where tick_o is high; half_i is reloaded on each tick.
// No backpressure; free-running whenever rst_i is low.
// Ports: clk_i ref clock, rst_i sync active-high reset, half_i half-period in ref cycles,
//        tick_o toggle tick (combinational, one cycle), level_o source level.
module ms_clk_tick_src
    import ms_clk_pkg::*;
#(
    parameter int HW = HALF_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [HW-1:0] half_i,
    output logic          tick_o,
    output logic          level_o
);

    logic [HW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] half_q, half_d;
    logic          level_q, level_d;
    logic          tick;

    assign tick = (cnt_q == half_q - HW'(1));

    // A new half-period only takes effect at a tick so the current half is never cut short.
    always_comb begin
        cnt_d   = cnt_q + HW'(1);
        half_d  = half_q;
        level_d = level_q;
        if (tick) begin
            cnt_d   = '0;
            half_d  = half_i;
            level_d = ~level_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            half_q  <= half_i;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            level_q <= level_d;
        end
    end

    assign tick_o  = tick;
    assign level_o = level_q;

endmodule

// File: rtl/ms_clk_rst.sv
// MS clock/reset generator: glitch-free 4-source clock mux, /1-/8 divider, POR and system reset.
// Latency: clk is registered one ref cycle behind the selected source level; rst_n asserts 1 cycle
// after a reset cause. No backpressure; a dead active source is abandoned after STALL_LIM cycles.
// Ports: clk_ref/rst ref clock and sync reset; xclk0/xclk1 external clocks sampled as data;
//        xrst_n async external reset; sel_mux0..2, sel_rosc, clk_div selects; clk, rst_n, por_n out.
module ms_clk_rst
    import ms_clk_pkg::*;
#(
    parameter int OSC_HALF   = DEF_OSC_HALF,
    parameter int ROSC_HALF0 = DEF_ROSC_HALF0,
    parameter int ROSC_STEP  = DEF_ROSC_STEP,
    parameter int POR_CYCLES = DEF_POR_CYCLES,
    parameter int STALL_LIM  = DEF_STALL_LIM
) (
    input  logic       clk_ref,
    input  logic       rst,
    input  logic       xclk0,
    input  logic       xclk1,
    input  logic       xrst_n,
    input  logic       sel_mux0,
    input  logic       sel_mux1,
    input  logic       sel_mux2,
    input  logic [1:0] sel_rosc,
    input  logic [1:0] clk_div,
    output logic       clk,
    output logic       rst_n,
    output logic       por_n
);

    localparam int POR_W = $clog2(POR_CYCLES + 1);
    localparam int ST_W  = $clog2(STALL_LIM + 1);

    // ---------------- internal sources ----------------
    logic osc_tick, osc_lvl, rosc_tick, rosc_lvl;

    ms_clk_tick_src #(.HW(HALF_W)) u_osc (
        .clk_i   (clk_ref),
        .rst_i   (rst),
        .half_i  (HALF_W'(OSC_HALF)),
        .tick_o  (osc_tick),
        .level_o (osc_lvl)
    );

    ms_clk_tick_src #(.HW(HALF_W)) u_rosc (
        .clk_i   (clk_ref),
        .rst_i   (rst),
        .half_i  (rosc_half(ROSC_HALF0, ROSC_STEP, sel_rosc)),
        .tick_o  (rosc_tick),
        .level_o (rosc_lvl)
    );

    // ---------------- state ----------------
    logic [2:0]       x0_sync_q, x1_sync_q;
    logic             x0_lvl_q, x0_lvl_d, x1_lvl_q, x1_lvl_d;
    logic [1:0]       xrst_sync_q;
    sw_state_e        st_q, st_d;
    src_e             act_q, act_d, tgt;
    logic [ST_W-1:0]  stall_q, stall_d;
    logic             mclk, mclk_q;
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       div_q, div_d;
    logic             clk_q, clk_d;
    logic [POR_W-1:0] por_cnt_q, por_cnt_d;
    logic             por_n_q, por_n_d;
    logic             rst_n_q, rst_n_d;
    logic [1:0]       rcnt_q, rcnt_d;

    logic       x0_tick, x1_tick;
    logic [3:0] src_tick, src_lvl;
    logic       act_lvl, act_tick, tgt_rise, dead, mclk_rise, clk_rise;

    // Every synchronized edge of an external clock is one toggle tick.
    assign x0_tick = x0_sync_q[2] ^ x0_sync_q[1];
    assign x1_tick = x1_sync_q[2] ^ x1_sync_q[1];
    assign x0_lvl_d = x0_lvl_q ^ x0_tick;
    assign x1_lvl_d = x1_lvl_q ^ x1_tick;

    assign src_tick = {x1_tick, x0_tick, rosc_tick, osc_tick};
    assign src_lvl  = {x1_lvl_q, x0_lvl_q, rosc_lvl, osc_lvl};

    // While the system is in reset the internal oscillator is always the target.
    always_comb begin
        if (!rst_n_q || !sel_mux0) tgt = SRC_OSC;
        else if (!sel_mux1)        tgt = SRC_ROSC;
        else if (!sel_mux2)        tgt = SRC_X0;
        else                       tgt = SRC_X1;
    end

    assign act_lvl  = src_lvl[act_q];
    assign act_tick = src_tick[act_q];
    assign tgt_rise = src_tick[tgt] & ~src_lvl[tgt];
    assign dead     = (stall_q == ST_W'(STALL_LIM));

    // ---------------- glitch-free mux FSM ----------------
    // Old source is released only while low (or dead); the new one is taken on its own
    // rising tick, so every high phase of mclk is a full half-period of one source.
    always_comb begin
        st_d  = st_q;
        act_d = act_q;
        unique case (st_q)
            SW_RUN: begin
                if (tgt != act_q) st_d = (act_lvl && !dead) ? SW_WAIT_LOW : SW_HOLD;
            end
            SW_WAIT_LOW: begin
                if (tgt == act_q)          st_d = SW_RUN;
                else if (!act_lvl || dead) st_d = SW_HOLD;
            end
            SW_HOLD: begin
                if (tgt_rise) begin
                    act_d = tgt;
                    st_d  = SW_RUN;
                end
            end
            default: st_d = SW_RUN;
        endcase
    end

    // Dead sources are forced low so a stopped clock never parks the output high.
    assign mclk = (st_q == SW_HOLD || dead) ? 1'b0 : act_lvl;

    always_comb begin
        stall_d = stall_q;
        if (act_d != act_q || act_tick) stall_d = '0;
        else if (!dead)                 stall_d = stall_q + ST_W'(1);
    end

    // ---------------- divider ----------------
    assign mclk_rise = mclk & ~mclk_q;

    always_comb begin
        cnt_d = mclk_rise ? cnt_q + 3'd1 : cnt_q;
        div_d = div_q;
        // cnt==0 with mclk low means every divider tap is low: a safe point to change ratio.
        if (cnt_q == 3'd0 && !mclk) div_d = rst_n_q ? clk_div : DIV_1;
        unique case (div_q)
            DIV_1:   clk_d = mclk;
            DIV_2:   clk_d = cnt_d[0];
            DIV_4:   clk_d = cnt_d[1];
            default: clk_d = cnt_d[2];
        endcase
    end

    assign clk_rise = clk_d & ~clk_q;

    // ---------------- POR and system reset ----------------
    always_comb begin
        por_cnt_d = por_cnt_q;
        por_n_d   = por_n_q;
        if (!por_n_q) begin
            por_cnt_d = por_cnt_q + POR_W'(1);
            if (por_cnt_q == POR_W'(POR_CYCLES - 1)) por_n_d = 1'b1;
        end
    end

    always_comb begin
        rst_n_d = rst_n_q;
        rcnt_d  = rcnt_q;
        if (!por_n_q || !xrst_sync_q[1]) begin
            rst_n_d = 1'b0;
            rcnt_d  = 2'd0;
        end else if (!rst_n_q && clk_rise) begin
            // Release on the second generated-clock rising edge once both causes clear.
            if (rcnt_q == 2'd1) rst_n_d = 1'b1;
            rcnt_d = rcnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            x0_sync_q   <= '0;
            x1_sync_q   <= '0;
            x0_lvl_q    <= 1'b0;
            x1_lvl_q    <= 1'b0;
            xrst_sync_q <= '0;
            st_q        <= SW_RUN;
            act_q       <= SRC_OSC;
            stall_q     <= '0;
            mclk_q      <= 1'b0;
            cnt_q       <= '0;
            div_q       <= DIV_1;
            clk_q       <= 1'b0;
            por_cnt_q   <= '0;
            por_n_q     <= 1'b0;
            rst_n_q     <= 1'b0;
            rcnt_q      <= '0;
        end else begin
            x0_sync_q   <= {x0_sync_q[1:0], xclk0};
            x1_sync_q   <= {x1_sync_q[1:0], xclk1};
            x0_lvl_q    <= x0_lvl_d;
            x1_lvl_q    <= x1_lvl_d;
            xrst_sync_q <= {xrst_sync_q[0], xrst_n};
            st_q        <= st_d;
            act_q       <= act_d;
            stall_q     <= stall_d;
            mclk_q      <= mclk;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            clk_q       <= clk_d;
            por_cnt_q   <= por_cnt_d;
            por_n_q     <= por_n_d;
            rst_n_q     <= rst_n_d;
            rcnt_q      <= rcnt_d;
        end
    end

    assign clk   = clk_q;
    assign por_n = por_n_q;
    assign rst_n = rst_n_q;

endmodule

// File: tb/tb_ms_clk_rst.sv
module tb_ms_clk_rst;

    logic       clk_ref = 1'b0;
    logic       rst = 1'b1;
    logic       xclk0 = 1'b0;
    logic       xclk1 = 1'b0;
    logic       xrst_n = 1'b1;
    logic       sel_mux0 = 1'b0;
    logic       sel_mux1 = 1'b0;
    logic       sel_mux2 = 1'b0;
    logic [1:0] sel_rosc = 2'd0;
    logic [1:0] clk_div = 2'd0;
    logic       clk, rst_n, por_n;

    int vec_cnt = 0;
    int err_cnt = 0;

    // External clock generators: toggle every xN_half ref cycles while enabled.
    bit x0_en = 1'b0;
    bit x1_en = 1'b0;
    int x0_half = 2;   // 25 MHz at 100 MHz ref
    int x1_half = 4;   // 12.5 MHz
    int x0_ph = 0;
    int x1_ph = 0;

    ms_clk_rst dut (
        .clk_ref  (clk_ref),
        .rst      (rst),
        .xclk0    (xclk0),
        .xclk1    (xclk1),
        .xrst_n   (xrst_n),
        .sel_mux0 (sel_mux0),
        .sel_mux1 (sel_mux1),
        .sel_mux2 (sel_mux2),
        .sel_rosc (sel_rosc),
        .clk_div  (clk_div),
        .clk      (clk),
        .rst_n    (rst_n),
        .por_n    (por_n)
    );

    always #5 clk_ref = ~clk_ref;

    always @(posedge clk_ref) begin
        #2;
        if (x0_en) begin
            x0_ph++;
            if (x0_ph >= x0_half) begin
                x0_ph = 0;
                xclk0 = ~xclk0;
            end
        end
        if (x1_en) begin
            x1_ph++;
            if (x1_ph >= x1_half) begin
                x1_ph = 0;
                xclk1 = ~xclk1;
            end
        end
    end

    // Advance n ref cycles; outputs are sampled 1 time unit after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_ref);
            #1;
        end
    endtask

    // Rising-to-rising clk period in ref cycles; -1 if no full period within bound.
    task automatic measure_period(input int bound, output int per);
        int   n;
        logic prev;
        bit   seen;
        per  = -1;
        seen = 1'b0;
        n    = 0;
        prev = clk;
        for (int i = 0; i < bound; i++) begin
            cyc(1);
            if (seen) n++;
            if (clk && !prev) begin
                if (seen) begin
                    per = n;
                    break;
                end
                seen = 1'b1;
                n    = 0;
            end
            prev = clk;
        end
    endtask

    task automatic test_reset();
        int   rises;
        int   per;
        logic prev;
        bit   done;
        rst = 1'b1;
        cyc(3);
        vec_cnt++;
        if (clk !== 1'b0) begin err_cnt++; $display("FAIL reset_clk got=%b exp=0", clk); end
        vec_cnt++;
        if (por_n !== 1'b0) begin err_cnt++; $display("FAIL reset_por_n got=%b exp=0", por_n); end
        vec_cnt++;
        if (rst_n !== 1'b0) begin err_cnt++; $display("FAIL reset_rst_n got=%b exp=0", rst_n); end
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            if (k == 15) begin
                vec_cnt++;
                if (por_n !== 1'b0) begin err_cnt++; $display("FAIL por_n_cycle15 got=%b exp=0", por_n); end
            end
            if (k == 16) begin
                vec_cnt++;
                if (por_n !== 1'b1) begin err_cnt++; $display("FAIL por_n_cycle16 got=%b exp=1", por_n); end
            end
        end
        rises = 0;
        prev  = clk;
        done  = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            cyc(1);
            if (clk && !prev) rises++;
            prev = clk;
            if (rst_n === 1'b1) done = 1'b1;
        end
        vec_cnt++;
        if (!done || rises != 2) begin
            err_cnt++;
            $display("FAIL por_rst_n_release rst_n=%b clk_rises=%0d exp_rises=2", rst_n, rises);
        end
        measure_period(60, per);
        vec_cnt++;
        if (per != 12) begin err_cnt++; $display("FAIL osc_period got=%0d exp=12", per); end
    endtask

    task automatic test_ext_clk();
        int   run;
        int   min_hi;
        int   per;
        logic prev;
        bit   valid;
        x0_en = 1'b1;
        cyc(8);
        sel_mux0 = 1'b1;
        sel_mux1 = 1'b1;
        sel_mux2 = 1'b0;
        // Shortest complete high pulse across the switch: must be >= xclk0 half-period (2).
        run    = 0;
        min_hi = 999;
        prev   = clk;
        valid  = !clk;
        for (int i = 0; i < 80; i++) begin
            cyc(1);
            if (clk) run++;
            else begin
                if (prev && valid && run < min_hi) min_hi = run;
                run   = 0;
                valid = 1'b1;
            end
            prev = clk;
        end
        vec_cnt++;
        if (min_hi < 2 || min_hi == 999) begin
            err_cnt++;
            $display("FAIL x0_min_high got=%0d exp>=2", min_hi);
        end
        measure_period(20, per);
        vec_cnt++;
        if (per != 4) begin err_cnt++; $display("FAIL x0_period got=%0d exp=4", per); end
    endtask

    task automatic test_rosc_div();
        int per;
        int exp_per[3];
        exp_per = '{20, 40, 80};
        sel_mux0 = 1'b0;
        cyc(30);
        sel_rosc = 2'd3;
        sel_mux1 = 1'b0;
        sel_mux0 = 1'b1;
        cyc(40);
        measure_period(60, per);
        measure_period(60, per);
        vec_cnt++;
        if (per != 10) begin err_cnt++; $display("FAIL rosc_period got=%0d exp=10", per); end
        for (int d = 1; d <= 3; d++) begin
            clk_div = 2'(d);
            cyc(100);
            measure_period(300, per);
            measure_period(300, per);
            vec_cnt++;
            if (per != exp_per[d-1]) begin
                err_cnt++;
                $display("FAIL rosc_div%0d_period got=%0d exp=%0d", d, per, exp_per[d-1]);
            end
        end
    endtask

    task automatic test_xrst();
        int   per;
        int   rises;
        logic prev;
        bit   done;
        clk_div = 2'd0;
        cyc(120);
        xrst_n = 1'b0;
        cyc(3);
        vec_cnt++;
        if (rst_n !== 1'b0) begin err_cnt++; $display("FAIL xrst_assert got=%b exp=0", rst_n); end
        cyc(30);
        measure_period(60, per);
        measure_period(60, per);
        vec_cnt++;
        if (per != 12) begin err_cnt++; $display("FAIL xrst_osc_period got=%0d exp=12", per); end
        vec_cnt++;
        if (por_n !== 1'b1) begin err_cnt++; $display("FAIL xrst_por_n got=%b exp=1", por_n); end
        // Release right after a clk rise so no generated edge falls inside the sync delay.
        prev = clk;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cyc(1);
            if (clk && !prev) done = 1'b1;
            prev = clk;
        end
        xrst_n = 1'b1;
        rises  = 0;
        done   = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            cyc(1);
            if (clk && !prev) rises++;
            prev = clk;
            if (rst_n === 1'b1) done = 1'b1;
        end
        vec_cnt++;
        if (!done || rises != 2) begin
            err_cnt++;
            $display("FAIL xrst_release rst_n=%b clk_rises=%0d exp_rises=2", rst_n, rises);
        end
    endtask

    task automatic test_stall_switch();
        int   rises;
        int   lat;
        int   per;
        logic prev;
        bit   done;
        sel_mux1 = 1'b1;
        sel_mux2 = 1'b0;
        cyc(40);
        // Stop xclk0 while high.
        for (int i = 0; i < 10; i++) begin
            if (xclk0) break;
            cyc(1);
        end
        x0_en = 1'b0;
        cyc(4);
        rises = 0;
        prev  = clk;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (clk && !prev) rises++;
            prev = clk;
        end
        vec_cnt++;
        if (rises != 0) begin err_cnt++; $display("FAIL x0_stall_rises got=%0d exp=0", rises); end
        x1_en    = 1'b1;
        sel_mux2 = 1'b1;
        lat  = 0;
        done = 1'b0;
        prev = clk;
        for (int i = 0; i < 258 && !done; i++) begin
            cyc(1);
            lat++;
            if (clk && !prev) done = 1'b1;
            prev = clk;
        end
        vec_cnt++;
        if (!done) begin err_cnt++; $display("FAIL stall_switch_latency got>%0d exp<=258", lat); end
        measure_period(30, per);
        measure_period(30, per);
        vec_cnt++;
        if (per != 8) begin err_cnt++; $display("FAIL x1_period got=%0d exp=8", per); end
    endtask

    task automatic test_all_stopped();
        int bad_clk;
        int bad_rst;
        for (int i = 0; i < 10; i++) begin
            if (!xclk1) break;
            cyc(1);
        end
        x1_en = 1'b0;
        cyc(6);
        bad_clk = 0;
        bad_rst = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (clk !== 1'b0) bad_clk++;
            if (por_n !== 1'b1 || rst_n !== 1'b1) bad_rst++;
        end
        vec_cnt++;
        if (bad_clk != 0) begin err_cnt++; $display("FAIL stopped_clk_static high_cycles=%0d exp=0", bad_clk); end
        vec_cnt++;
        if (bad_rst != 0) begin err_cnt++; $display("FAIL stopped_resets_held bad_cycles=%0d exp=0", bad_rst); end
    endtask

    initial begin
        test_reset();
        test_ext_clk();
        test_rosc_div();
        test_xrst();
        test_stall_switch();
        test_all_stopped();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
